// File: rtl/fft_symbol_scheduler.sv
// Gates the PSS-aligned sample stream into FFT windows for one SSB burst:
// forwards NUM_SYMBOLS windows of FFT_LEN samples and drops the CP between them.
module fft_symbol_scheduler #(
  parameter int IN_DW       = 32,
  parameter int FFT_LEN     = 256,
  parameter int CP_LEN      = 18,
  parameter int NUM_SYMBOLS = 4,
  localparam int SYM_W      = (NUM_SYMBOLS > 1) ? $clog2(NUM_SYMBOLS) : 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [IN_DW-1:0] s_axis_in_tdata,
  input  logic             s_axis_in_tvalid,
  input  logic             SSB_start_i,
  output logic [IN_DW-1:0] m_axis_out_tdata,
  output logic             m_axis_out_tvalid,
  output logic             m_axis_out_tlast,
  output logic [SYM_W-1:0] m_axis_out_tuser,
  output logic             symbol_start_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int SMP_W = (FFT_LEN > 1) ? $clog2(FFT_LEN) : 1;
  localparam int CP_W  = (CP_LEN > 0) ? $clog2(CP_LEN + 1) : 1;
  localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(FFT_LEN - 1);
  localparam logic [CP_W-1:0]  CP_LAST  = CP_W'((CP_LEN > 0) ? CP_LEN - 1 : 0);
  localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(NUM_SYMBOLS - 1);

  // ARM: start seen on an invalid cycle, waiting for the first valid sample
  typedef enum logic [2:0] {IDLE, ARM, WINDOW, CP, DONE} state_t;

  state_t           state, state_nx;
  logic [SMP_W-1:0] smp_cnt, smp_cnt_nx;
  logic [CP_W-1:0]  cp_cnt, cp_cnt_nx;
  logic [SYM_W-1:0] sym_cnt, sym_cnt_nx;

  logic [IN_DW-1:0] tdata_nx;
  logic             tvalid_nx, tlast_nx, sstart_nx, busy_nx, done_nx;
  logic [SYM_W-1:0] tuser_nx;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state             <= IDLE;
      smp_cnt           <= '0;
      cp_cnt            <= '0;
      sym_cnt           <= '0;
      m_axis_out_tdata  <= '0;
      m_axis_out_tvalid <= 1'b0;
      m_axis_out_tlast  <= 1'b0;
      m_axis_out_tuser  <= '0;
      symbol_start_o    <= 1'b0;
      busy_o            <= 1'b0;
      done_o            <= 1'b0;
    end else begin
      state             <= state_nx;
      smp_cnt           <= smp_cnt_nx;
      cp_cnt            <= cp_cnt_nx;
      sym_cnt           <= sym_cnt_nx;
      m_axis_out_tdata  <= tdata_nx;
      m_axis_out_tvalid <= tvalid_nx;
      m_axis_out_tlast  <= tlast_nx;
      m_axis_out_tuser  <= tuser_nx;
      symbol_start_o    <= sstart_nx;
      busy_o            <= busy_nx;
      done_o            <= done_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    smp_cnt_nx = smp_cnt;
    cp_cnt_nx  = cp_cnt;
    sym_cnt_nx = sym_cnt;
    tdata_nx   = m_axis_out_tdata;
    tvalid_nx  = 1'b0;
    tlast_nx   = 1'b0;
    tuser_nx   = m_axis_out_tuser;
    sstart_nx  = 1'b0;
    // DONE lasts one cycle whatever tvalid does; a start may override it below
    done_nx    = (state == DONE);
    if (state == DONE) state_nx = IDLE;

    if (SSB_start_i && !s_axis_in_tvalid) begin
      state_nx   = ARM;
      smp_cnt_nx = '0;
      cp_cnt_nx  = '0;
      sym_cnt_nx = '0;
    end else if (s_axis_in_tvalid && (SSB_start_i || state == ARM)) begin
      // start (or pending start) aborts whatever is running: this is window 0 sample 0
      state_nx   = WINDOW;
      smp_cnt_nx = SMP_W'(1);
      cp_cnt_nx  = '0;
      sym_cnt_nx = '0;
      tdata_nx   = s_axis_in_tdata;
      tvalid_nx  = 1'b1;
      tuser_nx   = '0;
      sstart_nx  = 1'b1;
    end else if (s_axis_in_tvalid) begin
      case (state)
        WINDOW: begin
          tdata_nx  = s_axis_in_tdata;
          tvalid_nx = 1'b1;
          tuser_nx  = sym_cnt;
          sstart_nx = (smp_cnt == '0);
          if (smp_cnt == SMP_LAST) begin
            tlast_nx   = 1'b1;
            smp_cnt_nx = '0;
            if (sym_cnt == SYM_LAST) begin
              state_nx = DONE;
            end else begin
              sym_cnt_nx = sym_cnt + SYM_W'(1);
              state_nx   = (CP_LEN > 0) ? CP : WINDOW;
            end
          end else begin
            smp_cnt_nx = smp_cnt + SMP_W'(1);
          end
        end
        CP: begin
          if (cp_cnt == CP_LAST) begin
            cp_cnt_nx = '0;
            state_nx  = WINDOW;
          end else begin
            cp_cnt_nx = cp_cnt + CP_W'(1);
          end
        end
        default: ;
      endcase
    end

    busy_nx = (state_nx == ARM) || (state_nx == WINDOW) || (state_nx == CP);
  end

endmodule

// File: tb/tb_fft_symbol_scheduler.sv
// Directed bench for fft_symbol_scheduler: default instance plus a small
// FFT_LEN=64/CP_LEN=5/NUM_SYMBOLS=2 instance sharing the same input stream.
module tb_fft_symbol_scheduler;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] tdata;
  logic        tvalid, start;

  logic [31:0] a_tdata, b_tdata;
  logic        a_tvalid, a_tlast, a_sstart, a_busy, a_done;
  logic [1:0]  a_tuser;
  logic        b_tvalid, b_tlast, b_sstart, b_busy, b_done;
  logic [0:0]  b_tuser;

  int total = 0, bad = 0, cyc = 0, s_cyc;
  int a_base, a_n, a_errs, a_lasts, a_gaps, a_dones, a_done_cyc;
  int b_base, b_n, b_errs, b_lasts, b_gaps, b_dones, b_done_cyc;
  int vidx;

  always #5 clk = ~clk;

  fft_symbol_scheduler dut_a (
    .clk_i(clk), .reset_i(rst), .s_axis_in_tdata(tdata), .s_axis_in_tvalid(tvalid),
    .SSB_start_i(start), .m_axis_out_tdata(a_tdata), .m_axis_out_tvalid(a_tvalid),
    .m_axis_out_tlast(a_tlast), .m_axis_out_tuser(a_tuser), .symbol_start_o(a_sstart),
    .busy_o(a_busy), .done_o(a_done));

  fft_symbol_scheduler #(.IN_DW(32), .FFT_LEN(64), .CP_LEN(5), .NUM_SYMBOLS(2)) dut_b (
    .clk_i(clk), .reset_i(rst), .s_axis_in_tdata(tdata), .s_axis_in_tvalid(tvalid),
    .SSB_start_i(start), .m_axis_out_tdata(b_tdata), .m_axis_out_tvalid(b_tvalid),
    .m_axis_out_tlast(b_tlast), .m_axis_out_tuser(b_tuser), .symbol_start_o(b_sstart),
    .busy_o(b_busy), .done_o(b_done));

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic mon_clr(input int ba, input int bb);
    a_base = ba; a_n = 0; a_errs = 0; a_lasts = 0; a_gaps = 0; a_dones = 0; a_done_cyc = -1;
    b_base = bb; b_n = 0; b_errs = 0; b_lasts = 0; b_gaps = 0; b_dones = 0; b_done_cyc = -1;
  endtask

  // Output j of a burst comes from ramp value base + j + (j/FFT_LEN)*CP_LEN
  task automatic step(input logic r, input logic v, input logic s, input logic [31:0] d);
    rst = r; tvalid = v; start = s; tdata = d;
    @(posedge clk); #1;
    cyc++;
    if (a_tvalid) begin
      if (a_tdata !== 32'(a_base + a_n + (a_n / 256) * 18)) a_errs++;
      if (a_tuser !== 2'(a_n / 256))                        a_errs++;
      if (a_tlast !== ((a_n % 256) == 255))                 a_errs++;
      if (a_sstart !== ((a_n % 256) == 0))                  a_errs++;
      if (a_tlast) a_lasts++;
      a_n++;
    end else if (a_n > 0 && a_n < 1024) a_gaps++;
    if (a_done) begin a_dones++; a_done_cyc = cyc; end
    if (b_tvalid) begin
      if (b_tdata !== 32'(b_base + b_n + (b_n / 64) * 5)) b_errs++;
      if (b_tuser !== 1'(b_n / 64))                       b_errs++;
      if (b_tlast !== ((b_n % 64) == 63))                 b_errs++;
      if (b_sstart !== ((b_n % 64) == 0))                 b_errs++;
      if (b_tlast) b_lasts++;
      b_n++;
    end else if (b_n > 0 && b_n < 128) b_gaps++;
    if (b_done) begin b_dones++; b_done_cyc = cyc; end
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    mon_clr(0, 0);
    rst = 1'b1; tvalid = 1'b0; start = 1'b0; tdata = 32'h1234_5678;
    do_reset();
    chk("rst_tdata", a_tdata, 0);
    chk("rst_tvalid", a_tvalid, 0);
    chk("rst_tlast", a_tlast, 0);
    chk("rst_tuser", a_tuser, 0);
    chk("rst_sstart", a_sstart, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);

    // Continuous valid ramp, start at sample 100
    mon_clr(100, 100);
    for (int i = 0; i < 100; i++) step(1'b0, 1'b1, 1'b0, 32'(i));
    chk("idle_no_out", a_n, 0);
    chk("idle_busy", a_busy, 0);
    step(1'b0, 1'b1, 1'b1, 32'd100);
    s_cyc = cyc;
    chk("s0_tvalid", a_tvalid, 1);
    chk("s0_sstart", a_sstart, 1);
    chk("s0_tdata", a_tdata, 100);
    chk("s0_busy", a_busy, 1);
    for (int i = 101; i < 1177; i++) step(1'b0, 1'b1, 1'b0, 32'(i));
    chk("t1_busy_mid", a_busy, 1);
    chk("t1_out_before_last", a_n, 1023);
    step(1'b0, 1'b1, 1'b0, 32'd1177);
    chk("t1_last_tlast", a_tlast, 1);
    chk("t1_last_tuser", a_tuser, 3);
    chk("t1_last_tdata", a_tdata, 1177);
    chk("t1_last_busy", a_busy, 0);
    step(1'b0, 1'b1, 1'b0, 32'd1178);
    chk("t1_done", a_done, 1);
    chk("t1_done_tvalid", a_tvalid, 0);
    step(1'b0, 1'b1, 1'b0, 32'd1179);
    chk("t1_done_once", a_done, 0);
    chk("t1_outs", a_n, 1024);
    chk("t1_lasts", a_lasts, 4);
    chk("t1_gaps", a_gaps, 54);
    chk("t1_errs", a_errs, 0);
    chk("t1_dones", a_dones, 1);
    // sample accepted at step s sits at the outputs after that step's edge
    chk("t1_done_cyc", a_done_cyc - s_cyc, 1078);

    // Toggling valid; start arrives on an invalid cycle and arms
    do_reset();
    vidx = 0;
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 1) begin step(1'b0, 1'b1, 1'b0, 32'(vidx)); vidx++; end
      else step(1'b0, 1'b0, 1'b0, 32'hDEAD);
    end
    mon_clr(vidx, vidx);
    step(1'b0, 1'b0, 1'b1, 32'hDEAD);
    chk("t2_arm_busy", a_busy, 1);
    chk("t2_arm_tvalid", a_tvalid, 0);
    for (int i = 0; i < 2170; i++) begin
      if (i % 2 == 0) begin step(1'b0, 1'b1, 1'b0, 32'(vidx)); vidx++; end
      else step(1'b0, 1'b0, 1'b0, 32'hDEAD);
    end
    chk("t2_outs", a_n, 1024);
    chk("t2_lasts", a_lasts, 4);
    chk("t2_errs", a_errs, 0);
    chk("t2_dones", a_dones, 1);
    chk("t2_busy_end", a_busy, 0);

    // Abort inside window 2 with a new start
    do_reset();
    mon_clr(0, 0);
    for (int i = 0; i < 600; i++) step(1'b0, 1'b1, i == 0, 32'(i));
    chk("t4_outs_pre", a_n, 564);
    chk("t4_lasts_pre", a_lasts, 2);
    chk("t4_errs_pre", a_errs, 0);
    chk("t4_dones_pre", a_dones, 0);
    mon_clr(600, 600);
    step(1'b0, 1'b1, 1'b1, 32'd600);
    chk("t4_restart_sstart", a_sstart, 1);
    chk("t4_restart_tuser", a_tuser, 0);
    chk("t4_restart_tdata", a_tdata, 600);
    for (int i = 601; i < 1681; i++) step(1'b0, 1'b1, 1'b0, 32'(i));
    chk("t4_outs", a_n, 1024);
    chk("t4_lasts", a_lasts, 4);
    chk("t4_errs", a_errs, 0);
    chk("t4_dones", a_dones, 1);

    // Reset while dropping the first CP
    do_reset();
    mon_clr(0, 0);
    for (int i = 0; i <= 260; i++) step(1'b0, 1'b1, i == 0, 32'(i));
    chk("t5_in_cp_tvalid", a_tvalid, 0);
    chk("t5_in_cp_busy", a_busy, 1);
    step(1'b1, 1'b1, 1'b0, 32'd261);
    chk("t5_rst_tdata", a_tdata, 0);
    chk("t5_rst_tvalid", a_tvalid, 0);
    chk("t5_rst_tuser", a_tuser, 0);
    chk("t5_rst_busy", a_busy, 0);
    chk("t5_rst_done", a_done, 0);
    mon_clr(0, 0);
    for (int i = 262; i < 312; i++) step(1'b0, 1'b1, 1'b0, 32'(i));
    chk("t5_ignored", a_n, 0);
    chk("t5_idle_busy", a_busy, 0);
    step(1'b0, 1'b1, 1'b1, 32'd77);
    chk("t5_new_sstart", a_sstart, 1);
    chk("t5_new_tdata", a_tdata, 77);

    // Small-parameter instance
    do_reset();
    mon_clr(10, 10);
    for (int i = 0; i < 150; i++) begin
      step(1'b0, 1'b1, i == 10, 32'(i));
      if (i == 10) s_cyc = cyc;
    end
    chk("t6_outs", b_n, 128);
    chk("t6_lasts", b_lasts, 2);
    chk("t6_gaps", b_gaps, 5);
    chk("t6_errs", b_errs, 0);
    chk("t6_dones", b_dones, 1);
    chk("t6_done_cyc", b_done_cyc - s_cyc, 133);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
